// File: rtl/box_sequencer_if.sv
// ---------------------------------------------------------------------------
// box_sequencer_if
//
// Bundles the request side and the pixel side of the box sequencer.
//
// Handshake semantics (both directions, stated once here):
//   * Request: the client raises `start` with x0/y0/width/height/colour_in/
//     outline valid in the same cycle. The request is taken only while the
//     sequencer is idle (busy=0). Once taken, the operands are latched and
//     the client may change them freely. `done` pulses for exactly one cycle
//     when the box is finished. `busy` falls in the cycle after `done`.
//   * Pixel: while drawing, x/y/colour/plot describe the current raster
//     position. That position is consumed on a rising edge where ready=1.
//     With ready=0, every pixel output holds. A position with plot=0
//     (interior of an outline or off-screen) still needs one ready cycle.
//
// Signals:
//   start, x0, y0, width, height, colour_in, outline  client -> sequencer
//   ready                                             display  -> sequencer
//   busy, done                                        sequencer -> client
//   x, y, colour, plot                                sequencer -> display
// ---------------------------------------------------------------------------
interface box_sequencer_if #(
    parameter int X_W = 8,
    parameter int Y_W = 7,
    parameter int S_W = 8,
    parameter int C_W = 3
) ();
    logic           start;
    logic [X_W-1:0] x0;
    logic [Y_W-1:0] y0;
    logic [S_W-1:0] width;
    logic [S_W-1:0] height;
    logic [C_W-1:0] colour_in;
    logic           outline;
    logic           ready;
    logic           busy;
    logic           done;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic [C_W-1:0] colour;
    logic           plot;

    // Client/display side
    modport master (
        output start, x0, y0, width, height, colour_in, outline, ready,
        input  busy, done, x, y, colour, plot
    );

    // Sequencer side
    modport slave (
        input  start, x0, y0, width, height, colour_in, outline, ready,
        output busy, done, x, y, colour, plot
    );
endinterface

// File: rtl/box_sequencer.sv
// ---------------------------------------------------------------------------
// box_sequencer
//
// Rectangle rasteriser for the VGA display path. A request latches a
// rectangle (origin, width, height, colour, fill/outline). The block then
// walks every position of the rectangle in row-major order, advancing one
// position per cycle in which the display accepts (ready=1). Positions that
// fall off-screen, or inside an outline-only box, are walked but not plotted.
// A zero width or zero height skips straight to the done pulse.
//
// Ports:
//   CLOCK_50     in   system clock, rising edge
//   resetn       in   asynchronous active-low reset; aborts any draw, no done
//   bus          slave modport of box_sequencer_if (request + pixel stream)
//   dbg_state_o  out  current FSM state (0=IDLE, 1=DRAW, 2=DONE)
//
// All outputs come straight from flops. The pixel registers are loaded with
// the position that the *next* state presents, so the first pixel appears
// the cycle after start is taken, and a stalled position simply reloads
// itself.
// ---------------------------------------------------------------------------
module box_sequencer #(
    parameter int X_W   = 8,
    parameter int Y_W   = 7,
    parameter int S_W   = 8,
    parameter int C_W   = 3,
    parameter int H_RES = 160,
    parameter int V_RES = 120
) (
    input  logic           CLOCK_50,
    input  logic           resetn,
    box_sequencer_if.slave bus,
    output logic [1:0]     dbg_state_o
);

    // Sums are one bit wider than the wider operand, so an origin near the
    // edge plus a large offset never wraps back on-screen.
    localparam int XS_W = ((X_W > S_W) ? X_W : S_W) + 1;
    localparam int YS_W = ((Y_W > S_W) ? Y_W : S_W) + 1;
    localparam logic [S_W-1:0] ONE_S = S_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;

    // Latched request
    logic [X_W-1:0] x0_q, x0_d;
    logic [Y_W-1:0] y0_q, y0_d;
    logic [S_W-1:0] w_q, w_d;
    logic [S_W-1:0] h_q, h_d;
    logic [C_W-1:0] colour_q, colour_d;
    logic           outline_q, outline_d;

    // Raster position within the box
    logic [S_W-1:0] col_q, col_d;
    logic [S_W-1:0] row_q, row_d;

    // Registered outputs
    logic [X_W-1:0] x_q, x_d;
    logic [Y_W-1:0] y_q, y_d;
    logic           plot_q, plot_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    // Screen position of the next pixel
    logic [XS_W-1:0] x_sum;
    logic [YS_W-1:0] y_sum;
    logic            visible;
    logic            on_edge;

    // -----------------------------------------------------------------------
    // Next-state: request latch, raster counters, FSM
    // -----------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        x0_d      = x0_q;
        y0_d      = y0_q;
        w_d       = w_q;
        h_d       = h_q;
        colour_d  = colour_q;
        outline_d = outline_q;
        col_d     = col_q;
        row_d     = row_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    x0_d      = bus.x0;
                    y0_d      = bus.y0;
                    w_d       = bus.width;
                    h_d       = bus.height;
                    colour_d  = bus.colour_in;
                    outline_d = bus.outline;
                    col_d     = '0;
                    row_d     = '0;
                    if ((bus.width == '0) || (bus.height == '0)) begin
                        state_d = DONE;
                    end else begin
                        state_d = DRAW;
                    end
                end
            end

            DRAW: begin
                // Every position, plotted or not, costs one accepted cycle.
                if (bus.ready) begin
                    if (col_q == (w_q - ONE_S)) begin
                        col_d = '0;
                        if (row_q == (h_q - ONE_S)) begin
                            state_d = DONE;
                        end else begin
                            row_d = row_q + ONE_S;
                        end
                    end else begin
                        col_d = col_q + ONE_S;
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Next-state: pixel outputs for the position the next state presents
    // -----------------------------------------------------------------------
    always_comb begin
        x_sum   = XS_W'(x0_d) + XS_W'(col_d);
        y_sum   = YS_W'(y0_d) + YS_W'(row_d);
        visible = (x_sum < XS_W'(H_RES)) && (y_sum < YS_W'(V_RES));
        // For a 1-wide or 1-high box the first and last column/row coincide,
        // so every pixel is an edge.
        on_edge = (col_d == '0) || (col_d == (w_d - ONE_S)) ||
                  (row_d == '0) || (row_d == (h_d - ONE_S));

        x_d    = x_q;
        y_d    = y_q;
        plot_d = 1'b0;
        if (state_d == DRAW) begin
            x_d    = x_sum[X_W-1:0];
            y_d    = y_sum[Y_W-1:0];
            plot_d = visible && (!outline_d || on_edge);
        end

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            x0_q      <= '0;
            y0_q      <= '0;
            w_q       <= '0;
            h_q       <= '0;
            colour_q  <= '0;
            outline_q <= 1'b0;
            col_q     <= '0;
            row_q     <= '0;
            x_q       <= '0;
            y_q       <= '0;
            plot_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            x0_q      <= x0_d;
            y0_q      <= y0_d;
            w_q       <= w_d;
            h_q       <= h_d;
            colour_q  <= colour_d;
            outline_q <= outline_d;
            col_q     <= col_d;
            row_q     <= row_d;
            x_q       <= x_d;
            y_q       <= y_d;
            plot_q    <= plot_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.x       = x_q;
    assign bus.y       = y_q;
    assign bus.colour  = colour_q;
    assign bus.plot    = plot_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_box_sequencer.sv
// ---------------------------------------------------------------------------
// tb_box_sequencer
//
// Drives rectangle requests into box_sequencer and records one observation
// per cycle after the request is taken, up to and including the first idle
// cycle. The reference model expands a rectangle into its row-major list of
// screen positions, then stretches that list over the ready pattern to give
// the expected per-cycle trace.
// ---------------------------------------------------------------------------
module tb_box_sequencer;

    localparam int X_W   = 8;
    localparam int Y_W   = 7;
    localparam int S_W   = 8;
    localparam int C_W   = 3;
    localparam int H_RES = 160;
    localparam int V_RES = 120;

    typedef struct packed {
        logic           busy;
        logic           done;
        logic           plot;
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
        logic [C_W-1:0] colour;
    } obs_t;

    logic       clk;
    logic       resetn;
    logic [1:0] dbg_state;

    box_sequencer_if #(.X_W(X_W), .Y_W(Y_W), .S_W(S_W), .C_W(C_W)) bus ();

    box_sequencer #(
        .X_W(X_W), .Y_W(Y_W), .S_W(S_W), .C_W(C_W), .H_RES(H_RES), .V_RES(V_RES)
    ) dut (
        .CLOCK_50    (clk),
        .resetn      (resetn),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    // Clock / reset ----------------------------------------------------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    // Scoreboard state -------------------------------------------------------
    obs_t obs_q[$];
    obs_t exp_q[$];
    obs_t care_q[$];
    bit   plan[$];
    int   mid_start_cycle;
    int   checks;
    int   errors;

    // ready to present during cycle k (k=1 is the first cycle after start)
    function automatic bit plan_at(input int k);
        if ((k - 1) < plan.size()) return plan[k-1];
        return 1'b1;
    endfunction

    // Reference model: every position of the box in row-major order, each
    // shown until a cycle with ready=1 takes it, then one done cycle, then
    // one idle cycle. Pixel fields only matter while drawing.
    function automatic void build_trace(input int x0, input int y0, input int w,
                                        input int h, input int c, input bit ol);
        obs_t e;
        obs_t m_all;
        obs_t m_ctl;
        int   k;
        int   xs;
        int   ys;
        bit   edge_px;
        bit   rdy;
        m_all      = '1;
        m_ctl      = '0;
        m_ctl.busy = 1'b1;
        m_ctl.done = 1'b1;
        m_ctl.plot = 1'b1;
        exp_q.delete();
        care_q.delete();
        k = 1;
        for (int r = 0; r < h; r++) begin
            for (int cc = 0; cc < w; cc++) begin
                xs      = x0 + cc;
                ys      = y0 + r;
                edge_px = (cc == 0) || (cc == w - 1) || (r == 0) || (r == h - 1);
                e        = '0;
                e.busy   = 1'b1;
                e.plot   = (xs < H_RES) && (ys < V_RES) && (!ol || edge_px);
                e.x      = X_W'(xs);
                e.y      = Y_W'(ys);
                e.colour = C_W'(c);
                do begin
                    exp_q.push_back(e);
                    care_q.push_back(m_all);
                    rdy = plan_at(k);
                    k++;
                end while (!rdy);
            end
        end
        e      = '0;
        e.busy = 1'b1;
        e.done = 1'b1;
        exp_q.push_back(e);
        care_q.push_back(m_ctl);
        e = '0;
        exp_q.push_back(e);
        care_q.push_back(m_ctl);
    endfunction

    function automatic int count_plots();
        int n;
        n = 0;
        foreach (obs_q[i]) if (obs_q[i].plot) n++;
        return n;
    endfunction

    function automatic int first_done_cycle();
        foreach (obs_q[i]) if (obs_q[i].done) return i + 1;
        return -1;
    endfunction

    // Driver: called at a negedge with the DUT idle. Issues one request and
    // records outputs each cycle until the first idle cycle is seen.
    task automatic draw_box(input int x0, input int y0, input int w, input int h,
                            input int c, input bit ol, input int max_cycles);
        obs_t o;
        obs_q.delete();
        bus.start     = 1'b1;
        bus.x0        = X_W'(x0);
        bus.y0        = Y_W'(y0);
        bus.width     = S_W'(w);
        bus.height    = S_W'(h);
        bus.colour_in = C_W'(c);
        bus.outline   = ol;
        bus.ready     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        for (int k = 1; k <= max_cycles; k++) begin
            o.busy   = bus.busy;
            o.done   = bus.done;
            o.plot   = bus.plot;
            o.x      = bus.x;
            o.y      = bus.y;
            o.colour = bus.colour;
            obs_q.push_back(o);
            if (!o.busy) break;
            bus.ready = plan_at(k);
            if (k == mid_start_cycle) begin
                // A competing request with different operands
                bus.start     = 1'b1;
                bus.x0        = ~bus.x0;
                bus.y0        = ~bus.y0;
                bus.width     = 8'd1;
                bus.height    = 8'd1;
                bus.colour_in = ~bus.colour_in;
                bus.outline   = ~bus.outline;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        bus.ready = 1'b1;
    endtask

    // Tests ------------------------------------------------------------------
    task automatic test_reset();
        checks++;
        if ({bus.busy, bus.done, bus.plot} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: got busy/done/plot=%b want 000", {bus.busy, bus.done, bus.plot});
        end
        checks++;
        if ({bus.x, bus.y, bus.colour} !== '0) begin
            errors++;
            $display("FAIL reset_pixel: got x=%0d y=%0d colour=%0d want 0 0 0", bus.x, bus.y, bus.colour);
        end
        checks++;
        if (dbg_state !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: got %0d want 0", dbg_state);
        end
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.busy, bus.done, bus.plot} !== 3'b000) begin
            errors++;
            $display("FAIL post_reset_idle: got busy/done/plot=%b want 000", {bus.busy, bus.done, bus.plot});
        end
    endtask

    task automatic test_fill();
        plan.delete();
        build_trace(10, 20, 3, 2, 5, 1'b0);
        draw_box(10, 20, 3, 2, 5, 1'b0, exp_q.size() + 8);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL fill_len: got %0d cycles want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if ((obs_q[i] & care_q[i]) !== (exp_q[i] & care_q[i])) begin
                errors++;
                $display("FAIL fill_trace cycle %0d: got %h want %h", i + 1, obs_q[i] & care_q[i], exp_q[i] & care_q[i]);
            end
        end
        checks++;
        if (count_plots() !== 6) begin
            errors++;
            $display("FAIL fill_plots: got %0d want 6", count_plots());
        end
        checks++;
        if (first_done_cycle() !== 7) begin
            errors++;
            $display("FAIL fill_done_cycle: got %0d want 7", first_done_cycle());
        end
        checks++;
        if (obs_q.size() < 8 || obs_q[7].busy !== 1'b0) begin
            errors++;
            $display("FAIL fill_busy_low: got trace of %0d cycles, busy not low on cycle 8", obs_q.size());
        end
    endtask

    task automatic test_outline();
        int draw_cycles;
        plan.delete();
        build_trace(0, 0, 4, 4, 2, 1'b1);
        draw_box(0, 0, 4, 4, 2, 1'b1, exp_q.size() + 8);
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if ((obs_q[i] & care_q[i]) !== (exp_q[i] & care_q[i])) begin
                errors++;
                $display("FAIL outline_trace cycle %0d: got %h want %h", i + 1, obs_q[i] & care_q[i], exp_q[i] & care_q[i]);
            end
        end
        draw_cycles = 0;
        foreach (obs_q[i]) if (obs_q[i].busy && !obs_q[i].done) draw_cycles++;
        checks++;
        if (draw_cycles !== 16) begin
            errors++;
            $display("FAIL outline_draw_cycles: got %0d want 16", draw_cycles);
        end
        checks++;
        if (count_plots() !== 12) begin
            errors++;
            $display("FAIL outline_plots: got %0d want 12", count_plots());
        end
        foreach (obs_q[i]) begin
            if (obs_q[i].busy && !obs_q[i].done && obs_q[i].x inside {8'd1, 8'd2} &&
                obs_q[i].y inside {7'd1, 7'd2}) begin
                checks++;
                if (obs_q[i].plot !== 1'b0) begin
                    errors++;
                    $display("FAIL outline_interior (%0d,%0d): got plot=1 want 0", obs_q[i].x, obs_q[i].y);
                end
            end
        end
    endtask

    task automatic test_clipping();
        plan.delete();
        build_trace(158, 118, 4, 4, 6, 1'b0);
        draw_box(158, 118, 4, 4, 6, 1'b0, exp_q.size() + 8);
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if ((obs_q[i] & care_q[i]) !== (exp_q[i] & care_q[i])) begin
                errors++;
                $display("FAIL clip_trace cycle %0d: got %h want %h", i + 1, obs_q[i] & care_q[i], exp_q[i] & care_q[i]);
            end
        end
        checks++;
        if (count_plots() !== 4) begin
            errors++;
            $display("FAIL clip_plots: got %0d want 4", count_plots());
        end
        foreach (obs_q[i]) begin
            if (obs_q[i].plot) begin
                checks++;
                if (!(obs_q[i].x inside {8'd158, 8'd159}) || !(obs_q[i].y inside {7'd118, 7'd119})) begin
                    errors++;
                    $display("FAIL clip_position: got plot at (%0d,%0d) want 158..159,118..119", obs_q[i].x, obs_q[i].y);
                end
            end
        end
        checks++;
        if (first_done_cycle() !== 17) begin
            errors++;
            $display("FAIL clip_done_cycle: got %0d want 17", first_done_cycle());
        end
    endtask

    task automatic test_backpressure();
        plan.delete();
        plan.push_back(1'b0);
        plan.push_back(1'b0);
        plan.push_back(1'b0);
        build_trace(40, 30, 2, 1, 7, 1'b0);
        draw_box(40, 30, 2, 1, 7, 1'b0, exp_q.size() + 8);
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if ((obs_q[i] & care_q[i]) !== (exp_q[i] & care_q[i])) begin
                errors++;
                $display("FAIL bp_trace cycle %0d: got %h want %h", i + 1, obs_q[i] & care_q[i], exp_q[i] & care_q[i]);
            end
        end
        for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
            checks++;
            if ({obs_q[i].plot, obs_q[i].x, obs_q[i].y} !== {1'b1, 8'd40, 7'd30}) begin
                errors++;
                $display("FAIL bp_hold cycle %0d: got plot=%0b (%0d,%0d) want plot=1 (40,30)", i + 1, obs_q[i].plot, obs_q[i].x, obs_q[i].y);
            end
        end
        checks++;
        if (obs_q.size() < 5 || {obs_q[4].plot, obs_q[4].x} !== {1'b1, 8'd41}) begin
            errors++;
            $display("FAIL bp_second_pixel: second pixel (41,30) not shown on cycle 5");
        end
        checks++;
        if (first_done_cycle() !== 6) begin
            errors++;
            $display("FAIL bp_done_cycle: got %0d want 6", first_done_cycle());
        end
        plan.delete();
    endtask

    task automatic test_zero_size();
        plan.delete();
        build_trace(12, 34, 0, 5, 3, 1'b0);
        draw_box(12, 34, 0, 5, 3, 1'b0, exp_q.size() + 8);
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if ((obs_q[i] & care_q[i]) !== (exp_q[i] & care_q[i])) begin
                errors++;
                $display("FAIL zero_trace cycle %0d: got %h want %h", i + 1, obs_q[i] & care_q[i], exp_q[i] & care_q[i]);
            end
        end
        checks++;
        if (first_done_cycle() !== 1) begin
            errors++;
            $display("FAIL zero_done_cycle: got %0d want 1", first_done_cycle());
        end
        checks++;
        if (count_plots() !== 0) begin
            errors++;
            $display("FAIL zero_plots: got %0d want 0", count_plots());
        end
    endtask

    task automatic test_ignored_start();
        plan.delete();
        mid_start_cycle = 3;
        build_trace(70, 60, 3, 3, 4, 1'b0);
        draw_box(70, 60, 3, 3, 4, 1'b0, exp_q.size() + 8);
        mid_start_cycle = 0;
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL ign_len: got %0d cycles want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if ((obs_q[i] & care_q[i]) !== (exp_q[i] & care_q[i])) begin
                errors++;
                $display("FAIL ign_trace cycle %0d: got %h want %h", i + 1, obs_q[i] & care_q[i], exp_q[i] & care_q[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        plan.delete();
        draw_box(50, 50, 2, 2, 1, 1'b0, 20);
        // The driver returns in the first idle cycle, so this request lands
        // at the earliest legal point.
        build_trace(60, 70, 3, 1, 6, 1'b1);
        draw_box(60, 70, 3, 1, 6, 1'b1, exp_q.size() + 8);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL b2b_len: got %0d cycles want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if ((obs_q[i] & care_q[i]) !== (exp_q[i] & care_q[i])) begin
                errors++;
                $display("FAIL b2b_trace cycle %0d: got %h want %h", i + 1, obs_q[i] & care_q[i], exp_q[i] & care_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid_draw();
        bit saw_done;
        plan.delete();
        bus.start     = 1'b1;
        bus.x0        = 8'd5;
        bus.y0        = 7'd5;
        bus.width     = 8'd3;
        bus.height    = 8'd3;
        bus.colour_in = 3'd3;
        bus.outline   = 1'b0;
        bus.ready     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        // Cycle 4: the fourth pixel, (5,6)
        checks++;
        if ({bus.busy, bus.plot, bus.x, bus.y} !== {1'b1, 1'b1, 8'd5, 7'd6}) begin
            errors++;
            $display("FAIL rst_pre_pixel: got busy=%0b plot=%0b (%0d,%0d) want 1 1 (5,6)", bus.busy, bus.plot, bus.x, bus.y);
        end
        #2 resetn = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.plot, bus.x, bus.y, bus.colour} !== '0) begin
            errors++;
            $display("FAIL rst_async_outputs: got busy=%0b done=%0b plot=%0b x=%0d y=%0d colour=%0d want all 0",
                     bus.busy, bus.done, bus.plot, bus.x, bus.y, bus.colour);
        end
        checks++;
        if (dbg_state !== 2'd0) begin
            errors++;
            $display("FAIL rst_async_state: got %0d want 0", dbg_state);
        end
        saw_done = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1 if (bus.done) saw_done = 1'b1;
        end
        @(negedge clk);
        resetn = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (bus.done || bus.busy) saw_done = 1'b1;
        end
        checks++;
        if (saw_done !== 1'b0) begin
            errors++;
            $display("FAIL rst_no_done: got activity after abort want none");
        end
        build_trace(30, 40, 2, 2, 5, 1'b0);
        draw_box(30, 40, 2, 2, 5, 1'b0, exp_q.size() + 8);
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if ((obs_q[i] & care_q[i]) !== (exp_q[i] & care_q[i])) begin
                errors++;
                $display("FAIL rst_redraw cycle %0d: got %h want %h", i + 1, obs_q[i] & care_q[i], exp_q[i] & care_q[i]);
            end
        end
    endtask

    task automatic test_random();
        int x0, y0, w, h, c;
        bit ol;
        for (int n = 0; n < 20; n++) begin
            x0 = $urandom_range(0, 255);
            y0 = $urandom_range(0, 127);
            w  = $urandom_range(0, 6);
            h  = $urandom_range(0, 6);
            if ($urandom_range(0, 4) == 0) w = $urandom_range(7, 40);
            c  = $urandom_range(0, 7);
            ol = 1'($urandom_range(0, 1));
            plan.delete();
            for (int k = 0; k < 2 * w * h + 4; k++) plan.push_back($urandom_range(0, 3) != 0);
            build_trace(x0, y0, w, h, c, ol);
            draw_box(x0, y0, w, h, c, ol, exp_q.size() + 8);
            checks++;
            if (obs_q.size() !== exp_q.size()) begin
                errors++;
                $display("FAIL rand_len box %0d: got %0d cycles want %0d", n, obs_q.size(), exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
                checks++;
                if ((obs_q[i] & care_q[i]) !== (exp_q[i] & care_q[i])) begin
                    errors++;
                    $display("FAIL rand_trace box %0d cycle %0d: got %h want %h", n, i + 1, obs_q[i] & care_q[i], exp_q[i] & care_q[i]);
                end
            end
        end
        plan.delete();
    endtask

    // Sequence ---------------------------------------------------------------
    initial begin
        checks          = 0;
        errors          = 0;
        mid_start_cycle = 0;
        resetn          = 1'b0;
        bus.start       = 1'b0;
        bus.x0          = '0;
        bus.y0          = '0;
        bus.width       = '0;
        bus.height      = '0;
        bus.colour_in   = '0;
        bus.outline     = 1'b0;
        bus.ready       = 1'b1;
        repeat (2) @(negedge clk);

        test_reset();
        test_fill();
        test_outline();
        test_clipping();
        test_backpressure();
        test_zero_size();
        test_ignored_start();
        test_back_to_back();
        test_reset_mid_draw();
        test_random();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
